// File: rtl/bsg_relay_credit_sender.sv
// bsg_relay_credit_sender
//   Transmit end of a credit-flowed relay link. Local ready/valid traffic is
//   staged in a two-entry buffer and launched onto the link from registered
//   outputs only while credits remain. The far end is a relay FIFO that is
//   credits_p deep, so it can never overflow.
//
// Ports
//   clk_i      : clock, all state updates on posedge
//   reset_n_i  : asynchronous active-low reset
//   v_i        : local valid
//   data_i     : local data
//   ready_o    : local ready; a transfer happens when v_i & ready_o
//   v_o        : link valid (registered)
//   data_o     : link data (registered)
//   credit_i   : one-cycle pulse per credit returned by the receiver
//   credits_o  : current credit count
//   error_o    : sticky credit-overflow flag
module bsg_relay_credit_sender #(
    parameter int width_p   = 64,
    parameter int credits_p = 2,
    localparam int ptr_width_lp = $clog2(credits_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    credit_i,
    output logic [ptr_width_lp-1:0] credits_o,
    output logic                    error_o
);

    localparam logic [ptr_width_lp-1:0] credits_max_lp = ptr_width_lp'(credits_p);

    // staging buffer state
    logic [width_p-1:0]      mem_q [2];
    logic                    head_q, head_d;
    logic                    tail_q, tail_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;

    // link and credit state
    logic                    v_q;
    logic [width_p-1:0]      data_q, data_d;
    logic [ptr_width_lp-1:0] credits_q, credits_d;
    logic                    error_q, error_d;

    // per-cycle decisions
    logic                    cand_v_s;
    logic [width_p-1:0]      cand_data_s;
    logic                    send_s;
    logic                    enq_s;
    logic                    deq_s;

    assign ready_o   = ~full_q;
    assign v_o       = v_q;
    assign data_o    = data_q;
    assign credits_o = credits_q;
    assign error_o   = error_q;

    // Candidate selection, send decision and next-state computation
    always_comb begin
        cand_v_s    = 1'b0;
        cand_data_s = mem_q[head_q];
        send_s      = 1'b0;
        enq_s       = 1'b0;
        deq_s       = 1'b0;
        head_d      = head_q;
        tail_d      = tail_q;
        full_d      = full_q;
        empty_d     = empty_q;
        data_d      = data_q;
        credits_d   = credits_q;
        error_d     = error_q;

        // Staged words go first; an empty buffer lets data_i fall through.
        if (!empty_q) begin
            cand_v_s    = 1'b1;
            cand_data_s = mem_q[head_q];
        end else if (v_i) begin
            cand_v_s    = 1'b1;
            cand_data_s = data_i;
        end else begin
            cand_v_s    = 1'b0;
            cand_data_s = mem_q[head_q];
        end

        // A credit arriving this cycle is only usable next cycle.
        send_s = cand_v_s & (credits_q != {ptr_width_lp{1'b0}});
        deq_s  = send_s & ~empty_q;
        // A word that fell straight through is not written to the buffer.
        enq_s  = v_i & ~full_q & ~(empty_q & send_s);

        head_d = head_q ^ deq_s;
        tail_d = tail_q ^ enq_s;

        case ({enq_s, deq_s})
            2'b10: begin
                empty_d = 1'b0;
                full_d  = (tail_d == head_q);
            end
            2'b01: begin
                full_d  = 1'b0;
                empty_d = (head_d == tail_q);
            end
            default: begin
                full_d  = full_q;
                empty_d = empty_q;
            end
        endcase

        if (send_s) begin
            data_d = cand_data_s;
        end else begin
            data_d = data_q;
        end

        case ({send_s, credit_i})
            2'b10: begin
                credits_d = credits_q - {{(ptr_width_lp-1){1'b0}}, 1'b1};
            end
            2'b01: begin
                // A credit beyond the maximum is a protocol violation: saturate and flag it.
                if (credits_q == credits_max_lp) begin
                    credits_d = credits_q;
                    error_d   = 1'b1;
                end else begin
                    credits_d = credits_q + {{(ptr_width_lp-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                credits_d = credits_q;
            end
        endcase
    end

    // Control, link and credit registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            v_q       <= 1'b0;
            data_q    <= {width_p{1'b0}};
            credits_q <= credits_max_lp;
            error_q   <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            v_q       <= send_s;
            data_q    <= data_d;
            credits_q <= credits_d;
            error_q   <= error_d;
        end
    end

    // Staging buffer storage, written at the tail on enqueue
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q[0] <= {width_p{1'b0}};
            mem_q[1] <= {width_p{1'b0}};
        end else if (enq_s) begin
            mem_q[tail_q] <= data_i;
        end else begin
            mem_q[0] <= mem_q[0];
            mem_q[1] <= mem_q[1];
        end
    end

endmodule
